// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: packs CMD_BYTES UART bytes (MSB first) into commands queued in a small FIFO,
//   drops stale partial frames after TIMEOUT_CYC idle clocks, and serialises a RESP_BYTES response.
// Latency: clr_rx_rdy one cycle after a byte is accepted; cmd_rdy one cycle after the final byte
//   (FIFO empty); tx_trmt two cycles after resp_trmt.
// Backpressure: a full FIFO drops the new command and pulses cmd_ovf; resp_trmt is ignored while
//   resp_busy; the transmitter paces bytes with tx_done.
// Ports: clk/rst (sync, active high); rx_rdy/rx_data/clr_rx_rdy byte input; cmd_rdy/cmd/clr_cmd_rdy
//   command FIFO head; cmd_ovf/frame_err error pulses; resp_trmt/resp/resp_busy/resp_done response
//   request; tx_trmt/tx_data/tx_done byte output to the UART transmitter.
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic                    cmd_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    clr_cmd_rdy,
  output logic                    cmd_ovf,
  output logic                    frame_err,
  input  logic                    resp_trmt,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_busy,
  output logic                    resp_done,
  output logic                    tx_trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int CMD_W   = 8 * CMD_BYTES;
  localparam int RESP_W  = 8 * RESP_BYTES;
  localparam int BCW     = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int TCW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int RCW     = $clog2(RESP_BYTES + 1);

  // ---------------- RX byte assembly ----------------
  logic [BCW-1:0]   bcnt;
  logic [CMD_W-1:0] shreg;
  logic [CMD_W-1:0] shreg_nxt;
  logic [TCW-1:0]   tcnt;
  logic             accept;
  logic             last_byte;
  logic             push;
  logic             tmo;

  // clr_rx_rdy masks the cycle after an accept so the same byte is never taken twice
  assign accept    = rx_rdy && !clr_rx_rdy;
  assign last_byte = (bcnt == BCW'(CMD_BYTES - 1));
  assign push      = accept && last_byte;
  assign shreg_nxt = (shreg << 8) | CMD_W'(rx_data);
  // tcnt is 0 in the cycle after an accept, so the frame is dropped on the TIMEOUT_CYC-th idle
  // edge; an accept in that same cycle keeps the frame alive
  assign tmo = (TIMEOUT_CYC > 0) && (bcnt != '0) && (tcnt == TCW'(TO_LAST)) && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rx_rdy <= 1'b0;
      frame_err  <= 1'b0;
      bcnt       <= '0;
      shreg      <= '0;
      tcnt       <= '0;
    end else begin
      clr_rx_rdy <= accept;
      frame_err  <= tmo;
      if (accept) begin
        shreg <= shreg_nxt;
        tcnt  <= '0;
        bcnt  <= last_byte ? '0 : bcnt + BCW'(1);
      end else if (tmo) begin
        // stale bytes left in shreg are shifted out by the next full frame
        bcnt <= '0;
        tcnt <= '0;
      end else if ((TIMEOUT_CYC > 0) && (bcnt != '0)) begin
        tcnt <= tcnt + TCW'(1);
      end
    end
  end

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      fifo_cnt;
  logic             fifo_full;
  logic             pop;
  logic             do_push;

  assign fifo_full = (fifo_cnt == (PW + 1)'(FIFO_DEPTH));
  assign pop       = clr_cmd_rdy && (fifo_cnt != '0);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push   = push && (!fifo_full || pop);
  assign cmd_rdy   = (fifo_cnt != '0);
  assign cmd       = cmd_rdy ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cmd_ovf  <= 1'b0;
    end else begin
      cmd_ovf <= push && fifo_full && !pop;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= shreg_nxt;
  end

  // ---------------- response serialiser ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  tx_state_t         tx_state;
  logic [RESP_W-1:0] tx_sh;
  logic [RCW-1:0]    tx_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_sh     <= '0;
      tx_left   <= '0;
      resp_busy <= 1'b0;
      resp_done <= 1'b0;
      tx_trmt   <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      tx_trmt   <= 1'b0;
      resp_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (resp_trmt) begin
            tx_sh     <= resp;
            tx_left   <= RCW'(RESP_BYTES);
            resp_busy <= 1'b1;
            tx_state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          tx_trmt  <= 1'b1;
          tx_data  <= tx_sh[RESP_W-1 -: 8];
          tx_left  <= tx_left - RCW'(1);
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            if (tx_left != '0) begin
              tx_sh    <= tx_sh << 8;
              tx_state <= TX_SEND;
            end else begin
              resp_done <= 1'b1;
              resp_busy <= 1'b0;
              tx_state  <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed bench for uart_cmd_framer with two parameter sets.
// u0: 2-byte commands, 3-byte responses, 2-deep FIFO, 100-cycle timeout.
// u1: 4-byte commands, 2-byte responses, timeout disabled, exercised with RX and TX concurrently.
module tb_uart_cmd_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- u0 ----------------
  logic        rst0, rx_rdy0, clr_rx_rdy0, cmd_rdy0, clr_cmd_rdy0, cmd_ovf0, frame_err0;
  logic [7:0]  rx_data0, tx_data0;
  logic [15:0] cmd0;
  logic        resp_trmt0, resp_busy0, resp_done0, tx_trmt0, tx_done0;
  logic [23:0] resp0;

  uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(3), .FIFO_DEPTH(2), .TIMEOUT_CYC(100)) u0 (
    .clk(clk), .rst(rst0), .rx_rdy(rx_rdy0), .rx_data(rx_data0), .clr_rx_rdy(clr_rx_rdy0),
    .cmd_rdy(cmd_rdy0), .cmd(cmd0), .clr_cmd_rdy(clr_cmd_rdy0), .cmd_ovf(cmd_ovf0),
    .frame_err(frame_err0), .resp_trmt(resp_trmt0), .resp(resp0), .resp_busy(resp_busy0),
    .resp_done(resp_done0), .tx_trmt(tx_trmt0), .tx_data(tx_data0), .tx_done(tx_done0)
  );

  // ---------------- u1 ----------------
  logic        rst1, rx_rdy1, clr_rx_rdy1, cmd_rdy1, clr_cmd_rdy1, cmd_ovf1, frame_err1;
  logic [7:0]  rx_data1, tx_data1;
  logic [31:0] cmd1;
  logic        resp_trmt1, resp_busy1, resp_done1, tx_trmt1, tx_done1;
  logic [15:0] resp1;

  uart_cmd_framer #(.CMD_BYTES(4), .RESP_BYTES(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(0)) u1 (
    .clk(clk), .rst(rst1), .rx_rdy(rx_rdy1), .rx_data(rx_data1), .clr_rx_rdy(clr_rx_rdy1),
    .cmd_rdy(cmd_rdy1), .cmd(cmd1), .clr_cmd_rdy(clr_cmd_rdy1), .cmd_ovf(cmd_ovf1),
    .frame_err(frame_err1), .resp_trmt(resp_trmt1), .resp(resp1), .resp_busy(resp_busy1),
    .resp_done(resp_done1), .tx_trmt(tx_trmt1), .tx_data(tx_data1), .tx_done(tx_done1)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_clr0 = 0, n_ovf0 = 0, n_fe0 = 0, n_rd0 = 0, n_rd1 = 0;
  int fe_cyc0 = -1;
  int acc0 = 0;
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (clr_rx_rdy0) n_clr0++;
    if (cmd_ovf0) n_ovf0++;
    if (frame_err0) begin n_fe0++; fe_cyc0 = cyc; end
    if (resp_done0) n_rd0++;
    if (resp_done1) n_rd1++;
  end

  // UART transmitter models: capture the byte, answer tx_done after a fixed delay
  initial begin
    tx_done0 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trmt0) begin
        txq0.push_back(tx_data0);
        repeat (20) @(negedge clk);
        tx_done0 = 1'b1;
        @(negedge clk);
        tx_done0 = 1'b0;
      end
    end
  end

  initial begin
    tx_done1 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trmt1) begin
        txq1.push_back(tx_data1);
        repeat (5) @(negedge clk);
        tx_done1 = 1'b1;
        @(negedge clk);
        tx_done1 = 1'b0;
      end
    end
  end

  // byte held on rx_rdy for exactly one accepting edge; optional FIFO pop on the same edge
  task automatic send0(input logic [7:0] b, input logic pop_too);
    @(negedge clk);
    rx_rdy0 = 1'b1; rx_data0 = b; clr_cmd_rdy0 = pop_too; acc0 = cyc;
    @(negedge clk);
    rx_rdy0 = 1'b0; clr_cmd_rdy0 = 1'b0;
    check("clr_rx_rdy_k+1", {31'd0, clr_rx_rdy0}, 32'd1);
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clk);
    rx_rdy1 = 1'b1; rx_data1 = b;
    @(negedge clk);
    rx_rdy1 = 1'b0;
  endtask

  task automatic pop0();
    @(negedge clk);
    clr_cmd_rdy0 = 1'b1;
    @(negedge clk);
    clr_cmd_rdy0 = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, snap2, a, tsz;
    bit got_done;

    rst0 = 1'b1; rx_rdy0 = 1'b0; rx_data0 = 8'h00; clr_cmd_rdy0 = 1'b0; resp_trmt0 = 1'b0; resp0 = '0;
    rst1 = 1'b1; rx_rdy1 = 1'b0; rx_data1 = 8'h00; clr_cmd_rdy1 = 1'b0; resp_trmt1 = 1'b0; resp1 = '0;
    repeat (3) @(negedge clk);
    check("reset_u0_outs", {cmd_rdy0, clr_rx_rdy0, cmd_ovf0, frame_err0, resp_busy0, resp_done0,
                            tx_trmt0, tx_data0, cmd0}, 32'd0);
    check("reset_u1_cmd", cmd1, 32'd0);
    check("reset_u1_flags", {24'd0, cmd_rdy1, clr_rx_rdy1, resp_busy1, tx_trmt1, frame_err1,
                             cmd_ovf1, resp_done1, 1'b0}, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // ---- basic 2-byte frame ----
    snap = n_clr0;
    send0(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    check("half_frame_not_rdy", {31'd0, cmd_rdy0}, 32'd0);
    send0(8'h3C, 1'b0);
    check("cmd_rdy_k+1", {31'd0, cmd_rdy0}, 32'd1);
    check("cmd_A53C", {16'd0, cmd0}, 32'hA53C);
    repeat (3) @(negedge clk);
    check("one_clr_per_byte", n_clr0 - snap, 32'd2);
    pop0();
    check("pop_empties", {31'd0, cmd_rdy0}, 32'd0);

    // ---- overflow with no pops ----
    snap = n_ovf0;
    send0(8'h01, 1'b0); send0(8'h02, 1'b0);
    send0(8'h03, 1'b0); send0(8'h04, 1'b0);
    send0(8'h05, 1'b0); send0(8'h06, 1'b0);
    repeat (2) @(negedge clk);
    check("ovf_once", n_ovf0 - snap, 32'd1);
    check("ovf_head_kept", {16'd0, cmd0}, 32'h0102);
    pop0();
    check("ovf_second", {16'd0, cmd0}, 32'h0304);
    pop0();
    check("ovf_drained", {31'd0, cmd_rdy0}, 32'd0);

    // ---- full FIFO with pop on the same edge as the push ----
    snap = n_ovf0;
    send0(8'h01, 1'b0); send0(8'h02, 1'b0);
    send0(8'h03, 1'b0); send0(8'h04, 1'b0);
    send0(8'h05, 1'b0); send0(8'h06, 1'b1);
    repeat (2) @(negedge clk);
    check("pushpop_no_ovf", n_ovf0 - snap, 32'd0);
    check("pushpop_head", {16'd0, cmd0}, 32'h0304);
    pop0();
    check("pushpop_next", {16'd0, cmd0}, 32'h0506);
    pop0();
    check("pushpop_drained", {31'd0, cmd_rdy0}, 32'd0);

    // ---- timeout drops a stale partial frame ----
    snap = n_fe0;
    send0(8'h11, 1'b0);
    a = acc0;
    wait_until(a + 150);
    send0(8'h22, 1'b0); send0(8'h33, 1'b0);
    repeat (3) @(negedge clk);
    check("fe_once", n_fe0 - snap, 32'd1);
    // frame_err rises on the 100th edge after the accepting edge
    check("fe_timing", fe_cyc0, a + 101);
    check("fe_cmd_2233", {16'd0, cmd0}, 32'h2233);
    pop0();
    check("fe_no_1122", {31'd0, cmd_rdy0}, 32'd0);

    // ---- byte accepted in the timeout cycle wins ----
    snap = n_fe0;
    send0(8'h11, 1'b0);
    a = acc0;
    wait_until(a + 99);
    send0(8'h22, 1'b0);
    repeat (110) @(negedge clk);
    check("edge_no_fe", n_fe0 - snap, 32'd0);
    check("edge_cmd_1122", {16'd0, cmd0}, 32'h1122);
    pop0();

    // ---- 3-byte response, retrigger mid-transfer ignored ----
    snap = n_rd0;
    tsz = txq0.size();
    @(negedge clk);
    resp0 = 24'hDEADBE; resp_trmt0 = 1'b1;
    @(negedge clk);
    resp_trmt0 = 1'b0;
    check("resp_busy_start", {31'd0, resp_busy0}, 32'd1);
    got_done = 1'b0;
    snap2 = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      resp_trmt0 = (i == 30);
      if (i >= 25) resp0 = 24'h123456;
      @(negedge clk);
      if (resp_done0) got_done = 1'b1;
      else if (!resp_busy0) snap2++;
    end
    resp_trmt0 = 1'b0;
    check("resp_done_seen", {31'd0, got_done}, 32'd1);
    check("resp_busy_held", snap2, 32'd0);
    repeat (100) @(negedge clk);
    check("resp_done_once", n_rd0 - snap, 32'd1);
    check("resp_byte_count", txq0.size() - tsz, 32'd3);
    if (txq0.size() - tsz == 3) begin
      check("resp_b0", {24'd0, txq0[tsz]}, 32'hDE);
      check("resp_b1", {24'd0, txq0[tsz + 1]}, 32'hAD);
      check("resp_b2", {24'd0, txq0[tsz + 2]}, 32'hBE);
    end
    check("resp_idle_after", {31'd0, resp_busy0}, 32'd0);

    // ---- reset mid-frame and mid-response ----
    snap = n_rd0;
    snap2 = n_fe0;
    tsz = txq0.size();
    @(negedge clk);
    resp0 = 24'h0A0B0C; resp_trmt0 = 1'b1;
    @(negedge clk);
    resp_trmt0 = 1'b0;
    send0(8'h99, 1'b0); send0(8'h99, 1'b0);
    send0(8'h55, 1'b0);
    @(negedge clk);
    check("pre_rst_busy", {cmd_rdy0, resp_busy0}, 32'd3);
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {cmd_rdy0, clr_rx_rdy0, cmd_ovf0, frame_err0, resp_busy0, resp_done0,
                           tx_trmt0, tx_data0, cmd0}, 32'd0);
    rst0 = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_resp_done", n_rd0 - snap, 32'd0);
    check("rst_one_byte_sent", txq0.size() - tsz, 32'd1);
    check("rst_stays_idle", {31'd0, resp_busy0}, 32'd0);
    send0(8'h77, 1'b0); send0(8'h88, 1'b0);
    check("rst_cmd_7788", {16'd0, cmd0}, 32'h7788);
    repeat (2) @(negedge clk);
    check("rst_no_fe", n_fe0 - snap2, 32'd0);
    pop0();
    check("rst_fifo_single", {31'd0, cmd_rdy0}, 32'd0);

    // ---- u1: 4-byte command while a 2-byte response runs ----
    snap = n_rd1;
    got_done = 1'b0;
    fork
      begin
        for (int b = 1; b <= 4; b++) begin
          send1(8'(b));
          repeat (10) @(negedge clk);
        end
      end
      begin
        @(negedge clk);
        resp1 = 16'hCAFE; resp_trmt1 = 1'b1;
        @(negedge clk);
        resp_trmt1 = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
          @(negedge clk);
          if (resp_done1) got_done = 1'b1;
        end
      end
    join
    repeat (5) @(negedge clk);
    check("u1_cmd_rdy", {31'd0, cmd_rdy1}, 32'd1);
    check("u1_cmd", cmd1, 32'h01020304);
    check("u1_resp_done", {31'd0, got_done}, 32'd1);
    check("u1_resp_done_once", n_rd1 - snap, 32'd1);
    check("u1_byte_count", txq1.size(), 32'd2);
    if (txq1.size() == 2) begin
      check("u1_b0", {24'd0, txq1[0]}, 32'hCA);
      check("u1_b1", {24'd0, txq1[1]}, 32'hFE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
